// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a TX FIFO on the CPU store bus.
// Optional even-parity bit: define UART_TX_PARITY_EN.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0400,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        mem_write_i,
  input  logic [31:0] data_adr_i,
  input  logic [31:0] write_data_i,
  output logic [31:0] read_data_o,
  output logic        tx_o,
  output logic        busy_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST    = CW'(CLKS_PER_BIT - 1);
  localparam logic [31:0]   STATUS_ADDR = BASE_ADDR + 32'd4;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [2:0]    idx, idx_nx;
  logic [7:0]    shift, shift_nx;
  logic          tx_r, tx_nx;
  logic          busy_r, busy_nx;
  logic          overflow;

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, wr_ptr_nx, rd_ptr_nx, count;
  logic          full, empty, push_req, push, pop, drop, clr;
  logic [7:0]    head;
  logic          tick;
  logic          unused_bits;

  assign unused_bits = ^write_data_i[31:8];

  assign count    = wr_ptr - rd_ptr;
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head     = fifo_mem[rd_ptr[AW-1:0]];
  assign push_req = mem_write_i && (data_adr_i == BASE_ADDR);
  // A full FIFO still takes the byte when the FSM pops in the same cycle.
  assign push     = push_req && (!full || pop);
  assign drop     = push_req && !push;
  assign clr      = mem_write_i && (data_adr_i == STATUS_ADDR);
  assign tick     = (cnt == CNT_LAST);

  assign wr_ptr_nx = wr_ptr + {{AW{1'b0}}, push};
  assign rd_ptr_nx = rd_ptr + {{AW{1'b0}}, pop};

  // FSM next state, bit timing, pop request and next line level
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    idx_nx   = idx;
    pop      = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_nx = '0;
        if (!empty) begin
          pop      = 1'b1;
          state_nx = S_START;
        end else begin
          state_nx = S_IDLE;
        end
      end
      S_START: begin
        if (tick) begin
          cnt_nx   = '0;
          idx_nx   = 3'd0;
          state_nx = S_DATA;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (tick) begin
          cnt_nx = '0;
          if (idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_nx = S_PARITY;
`else
            state_nx = S_STOP;
`endif
          end else begin
            idx_nx = idx + 3'd1;
          end
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      S_PARITY: begin
        if (tick) begin
          cnt_nx   = '0;
          state_nx = S_STOP;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      S_STOP: begin
        if (tick) begin
          cnt_nx = '0;
          if (!empty) begin
            pop      = 1'b1;
            state_nx = S_START;
          end else begin
            state_nx = S_IDLE;
          end
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: begin
        cnt_nx   = '0;
        idx_nx   = 3'd0;
        state_nx = S_IDLE;
      end
    endcase

    if (pop) begin
      shift_nx = head;
    end else begin
      shift_nx = shift;
    end

    case (state_nx)
      S_START:  tx_nx = 1'b0;
      S_DATA:   tx_nx = shift_nx[idx_nx];
      S_PARITY: tx_nx = even_parity(shift_nx);
      default:  tx_nx = 1'b1;
    endcase

    busy_nx = (state_nx != S_IDLE) || (wr_ptr_nx != rd_ptr_nx);
  end

  // FSM, shift register, line driver and busy flag
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= S_IDLE;
      cnt    <= '0;
      idx    <= 3'd0;
      shift  <= 8'h00;
      tx_r   <= 1'b1;
      busy_r <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      idx    <= idx_nx;
      shift  <= shift_nx;
      tx_r   <= tx_nx;
      busy_r <= busy_nx;
    end
  end

  // FIFO pointers and sticky overflow flag
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr_nx;
      rd_ptr <= rd_ptr_nx;
      if (drop) begin
        overflow <= 1'b1;
      end else if (clr) begin
        overflow <= 1'b0;
      end else begin
        overflow <= overflow;
      end
    end
  end

  // FIFO storage; contents are don't-care once the pointers reset
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_mem[wr_ptr[AW-1:0]] <= write_data_i[7:0];
    end
  end

  // STATUS read mux
  always_comb begin
    read_data_o = 32'h0000_0000;
    if (data_adr_i == STATUS_ADDR) begin
      read_data_o = {24'h00_0000, 4'(count), overflow, empty, full, busy_r};
    end else begin
      read_data_o = 32'h0000_0000;
    end
  end

  assign tx_o   = tx_r;
  assign busy_o = busy_r;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Scoreboard bench for mmio_uart_tx: a serial-line monitor decodes frames and
// compares them with bytes queued when the stores were driven.
module tb_mmio_uart_tx;

  localparam int C = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_write;
  logic [31:0] adr, wdata, rdata;
  logic        tx, busy;

  mmio_uart_tx #(
    .BASE_ADDR   (32'h0000_0400),
    .CLKS_PER_BIT(C),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .mem_write_i (mem_write),
    .data_adr_i  (adr),
    .write_data_i(wdata),
    .read_data_o (rdata),
    .tx_o        (tx),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] exp_q[$];
  bit         rst_seen = 1'b0;
  bit         b2b_check = 1'b0;
  int         last_start = -1;
  int         store_edge = 0;

  always @(posedge rst) rst_seen = 1'b1;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input bit sent);
    @(negedge clk);
    mem_write = 1'b1;
    adr       = a;
    wdata     = d;
    if (sent) exp_q.push_back(d[7:0]);
    @(posedge clk);
    #1;
    store_edge = cyc;
    mem_write  = 1'b0;
    adr        = 32'h0000_0000;
    wdata      = 32'h0000_0000;
  endtask

  task automatic read_status(output logic [31:0] v);
    adr = 32'h0000_0404;
    #1;
    v   = rdata;
    adr = 32'h0000_0000;
  endtask

  task automatic wait_drain(input string tag, input int limit);
    int i;
    for (i = 0; i < limit; i++) begin
      @(posedge clk);
      #1;
      if (!busy && exp_q.size() == 0) break;
    end
    check_value(tag, 32'(i < limit), 32'd1);
  endtask

  // Serial monitor: detects start bits, samples mid-bit and scores each frame
  initial begin : monitor
    logic [7:0] rx;
    logic [7:0] ev;
    logic       sb, pb, stp;
    int         start_c;
    forever begin
      @(posedge clk);
      #1;
      if (tx === 1'b0 && rst === 1'b0) begin
        start_c  = cyc;
        rst_seen = 1'b0;
        pb       = 1'b0;
        repeat (C / 2) @(posedge clk);
        #1;
        sb = tx;
        for (int i = 0; i < 8; i++) begin
          repeat (C) @(posedge clk);
          #1;
          rx[i] = tx;
        end
`ifdef UART_TX_PARITY_EN
        repeat (C) @(posedge clk);
        #1;
        pb = tx;
`endif
        repeat (C) @(posedge clk);
        #1;
        stp = tx;
        if (!rst_seen) begin
          check_value("start_bit", 32'(sb), 32'd0);
          check_value("frame_expected", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) begin
            ev = exp_q.pop_front();
            check_value("data_byte", 32'(rx), 32'(ev));
`ifdef UART_TX_PARITY_EN
            check_value("parity_bit", 32'(pb), 32'(^ev));
`endif
          end
          check_value("stop_bit", 32'(stp), 32'd1);
          if (b2b_check && last_start >= 0) begin
            check_value("b2b_gap", 32'(start_c - last_start), 32'(FRAME_BITS * C));
          end
          last_start = start_c;
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin : main
    logic [31:0] v;
    int          s;
    int          lows;
    rst       = 1'b1;
    mem_write = 1'b0;
    adr       = 32'h0000_0000;
    wdata     = 32'h0000_0000;
    repeat (3) @(posedge clk);
    #1;
    check_value("tx_in_reset", 32'(tx), 32'd1);
    read_status(v);
    check_value("status_in_reset", v, 32'h0000_0004);
    @(negedge clk);
    rst = 1'b0;

    // idle after reset
    repeat (50) @(posedge clk);
    #1;
    check_value("idle_tx", 32'(tx), 32'd1);
    check_value("idle_busy", 32'(busy), 32'd0);
    read_status(v);
    check_value("idle_status", v, 32'h0000_0004);

    // single frame 0x55 and busy timing
    store(32'h0000_0400, 32'h0000_0055, 1'b1);
    s = store_edge;
    check_value("busy_after_store", 32'(busy), 32'd1);
    read_status(v);
    check_value("status_one_queued", v, 32'h0000_0011);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (!busy) break;
    end
    check_value("busy_fall", 32'(cyc - s), 32'(1 + FRAME_BITS * C));
    wait_drain("drain_55", 50);

    // stores outside the window
    store(32'd100, 32'd7, 1'b0);
    store(32'd96, 32'h0000_0033, 1'b0);
    repeat (50) @(posedge clk);
    #1;
    check_value("foreign_tx", 32'(tx), 32'd1);
    read_status(v);
    check_value("foreign_status", v, 32'h0000_0004);

    // six back-to-back stores: 0x06 overflows
    last_start = -1;
    b2b_check  = 1'b1;
    for (int b = 1; b <= 6; b++) begin
      store(32'h0000_0400, 32'(b), b != 6);
    end
    read_status(v);
    check_value("status_overflow", v, 32'h0000_004B);
    store(32'h0000_0404, 32'h0000_0000, 1'b0);
    read_status(v);
    check_value("status_ovf_clear", v, 32'h0000_0043);
    wait_drain("drain_burst", 600);
    b2b_check = 1'b0;

    // reset during DATA of the second of three frames
    store(32'h0000_0400, 32'h0000_00A1, 1'b1);
    s = store_edge;
    store(32'h0000_0400, 32'h0000_00B2, 1'b1);
    store(32'h0000_0400, 32'h0000_00C3, 1'b1);
    while (cyc < s + 1 + FRAME_BITS * C + C + 10) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    #1;
    check_value("tx_async_reset", 32'(tx), 32'd1);
    check_value("busy_async_reset", 32'(busy), 32'd0);
    read_status(v);
    check_value("status_after_reset", v, 32'h0000_0004);
    exp_q.delete();
    @(negedge clk);
    rst  = 1'b0;
    lows = 0;
    for (int i = 0; i < 120; i++) begin
      @(posedge clk);
      #1;
      if (tx !== 1'b1) lows++;
    end
    check_value("no_frames_after_reset", 32'(lows), 32'd0);
    read_status(v);
    check_value("status_post_reset", v, 32'h0000_0004);

`ifdef UART_TX_PARITY_EN
    store(32'h0000_0400, 32'h0000_0007, 1'b1);
    s = store_edge;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (!busy) break;
    end
    check_value("busy_fall_parity", 32'(cyc - s), 32'(1 + 11 * C));
    wait_drain("drain_07", 50);
    store(32'h0000_0400, 32'h0000_0003, 1'b1);
    wait_drain("drain_03", 200);
`endif

    check_value("queue_empty_at_end", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter that sits on the processor's data-memory store bus, alongside data memory, and responds to `mem_write` cycles. The CPU stores bytes to a TXDATA address; the block queues them in a small FIFO and shifts them out serially as 8N1 frames on `tx_o`. A STATUS register lets software poll occupancy and a sticky overflow flag. Stores to any address outside its window are ignored.

## Interface
- `BASE_ADDR`, default 32'h0000_0400: word-aligned base of the register window.
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit, ≥2.
- `FIFO_DEPTH`, default 4: TX FIFO entries, power of two, ≥2.
- `clk_i` in 1: single clock, all state on rising edge.
- `rst_i` in 1: asynchronous, active-high reset.
- `mem_write_i` in 1: store strobe from CPU.
- `data_adr_i` in 32: byte address of the current access.
- `write_data_i` in 32: store data.
- `read_data_o` out 32: combinational read data for STATUS; 0 for any other address.
- `tx_o` out 1: serial line, idle high, registered.
- `busy_o` out 1: high while a frame is on the line or the FIFO is non-empty.

## Operation
- Register map:
  - BASE+0 TXDATA (write-only): push `write_data_i[7:0]`.
  - BASE+4 STATUS (read): bit0 busy, bit1 full, bit2 empty, bit3 overflow (sticky), bits[7:4] FIFO count, rest 0. Any store to BASE+4 clears overflow.
- Decode uses full 32-bit equality. Stores elsewhere, e.g. address 100 or 96, change nothing.
- Push is accepted when the FIFO is not full, or when it is full and a pop happens in the same cycle. Otherwise the byte is dropped and overflow is set.
- FSM states, each bit state lasting exactly `CLKS_PER_BIT` cycles:
  - IDLE: `tx_o`=1. If the FIFO is non-empty, pop the head into the shift register, go to START.
  - START: `tx_o`=0.
  - DATA: 8 bits, LSB first. A 3-bit index counts 0..7.
  - STOP: `tx_o`=1. At the end, pop and go to START if the FIFO is non-empty, else go to IDLE. There is no idle gap between queued frames.
- The bit counter counts 0..`CLKS_PER_BIT`-1 and wraps. The state advances on terminal count.
- FIFO uses a circular buffer. Pointers are log2(`FIFO_DEPTH`)+1 bits; full/empty come from the MSB compare. Count is saturating-free and exact.
- A STATUS clear and an overflowing push cannot occur in the same cycle, because there is a single address per cycle.

## Timing
- Reset values: `tx_o`=1, `busy_o`=0, FIFO empty, overflow=0, FSM=IDLE, counters=0. `read_data_o` reflects the reset state: STATUS reads 32'h0000_0004.
- Reset asserted mid-frame aborts immediately. `tx_o` goes to 1 asynchronously and queued bytes are discarded.
- Store at edge k into an empty idle block:
  - Byte is in the FIFO after k, and `busy_o`=1 after k.
  - Pop at edge k+1. `tx_o` falls after k+1.
  - Start bit runs from k+1 to k+1+`CLKS_PER_BIT`.
  - Stop bit ends at k+1+10·`CLKS_PER_BIT`. `busy_o` falls at that edge if nothing is queued.
- Back-to-back frames: the next start bit begins on the edge ending the previous stop bit.
- STATUS read is combinational from the current registered state, with zero latency.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - FSM inserts a PARITY state between DATA and STOP.
  - It transmits even parity (XOR of the 8 data bits) for `CLKS_PER_BIT` cycles.
  - Frame becomes 11·`CLKS_PER_BIT` cycles.
- `UART_TX_PARITY_EN` undefined: no PARITY state, 8N1 frames of 10·`CLKS_PER_BIT` cycles.

## Test plan
All scenarios use `CLKS_PER_BIT`=4, `FIFO_DEPTH`=4, BASE=0x400.
- Reset then idle 50 cycles → `tx_o`=1, `busy_o`=0, STATUS=0x4.
- Store 0x55 to 0x400 → `tx_o` sampled mid-bit reads 0,1,0,1,0,1,0,1,0,1. `busy_o` falls 41 cycles after the store edge.
- Store data 7 to address 100, then data 0x33 to address 96 → `tx_o` stays 1, STATUS unchanged at 0x4.
- Six stores of 0x01..0x06 in consecutive cycles:
  - Bytes 0x01..0x05 are sent back-to-back with no gap; 0x06 is dropped.
  - STATUS bit3=1.
  - A store to 0x404 clears bit3.
- Assert `rst_i` during DATA of frame 2 of 3 queued → `tx_o`=1 immediately, STATUS=0x4, no further frames.
- With `UART_TX_PARITY_EN`, send 0x07 → parity bit 1, frame 44 cycles. Send 0x03 → parity bit 0.
